// File: rtl/leaderboard_recorder_if.sv
// Bundles the game-side and renderer-side signals of the high-score table.
//   sec      : live score from the game timer
//   lose     : level, high while game-over
//   clr      : table clear request
//   rd_idx   : entry to read, 0 = best
//   rd_score : registered binary score of the addressed entry
//   rd_bcd   : registered BCD of the addressed entry, most significant digit in the MSBs
//   busy     : engine inserting or converting
//   done     : one-cycle pulse when the BCD cache is coherent again
//   new_rank : rank of the last insertion, DEPTH when not placed
//   dropped  : sticky, a game-over edge arrived while busy
// master drives the requests (game/renderer side); slave is the recorder.
interface leaderboard_recorder_if #(
  parameter int SCORE_W = 10,
  parameter int DIGITS  = 3
);
  logic [SCORE_W-1:0]  sec;
  logic                lose;
  logic                clr;
  logic [2:0]          rd_idx;
  logic [SCORE_W-1:0]  rd_score;
  logic [4*DIGITS-1:0] rd_bcd;
  logic                busy;
  logic                done;
  logic [3:0]          new_rank;
  logic                dropped;

  modport master (
    output sec, lose, clr, rd_idx,
    input  rd_score, rd_bcd, busy, done, new_rank, dropped
  );

  modport slave (
    input  sec, lose, clr, rd_idx,
    output rd_score, rd_bcd, busy, done, new_rank, dropped
  );
endinterface

// File: rtl/leaderboard_recorder.sv
// Sorted high-score table with a sequential double-dabble BCD cache.
// Ports:
//   clk : system clock
//   rst : asynchronous, active-high reset
//   bus : leaderboard_recorder_if.slave (score input, game-over level, clear,
//         registered read port, busy/done/new_rank/dropped status)
// Each rising edge of lose inserts the held score once; afterwards every
// entry is reconverted to BCD, one bit per cycle, SCORE_W cycles per entry.
module leaderboard_recorder #(
  parameter int SCORE_W = 10,
  parameter int DEPTH   = 3,
  parameter int DIGITS  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  leaderboard_recorder_if.slave bus
);

  function automatic longint pow10(input int n);
    longint r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam int     BCD_W    = 4 * DIGITS;
  localparam int     SR_W     = BCD_W + SCORE_W;
  localparam int     BC_W     = (SCORE_W > 1) ? $clog2(SCORE_W) : 1;
  localparam longint MAX_L    = pow10(DIGITS) - 1;
  localparam bit     SAT_ON   = MAX_L < (longint'(1) << SCORE_W);
  // When every SCORE_W value fits in DIGITS digits, the threshold is all ones
  // so the saturation compare can never fire.
  localparam logic [SCORE_W-1:0] MAX_DISP = SAT_ON ? SCORE_W'(MAX_L) : '1;

  // One double-dabble step: +3 on any BCD nibble >= 5, then shift left.
  function automatic logic [SR_W-1:0] dd_step(input logic [SR_W-1:0] s);
    logic [SR_W-1:0] r;
    r = s;
    for (int d = 0; d < DIGITS; d++)
      if (r[SCORE_W+4*d +: 4] >= 4'd5)
        r[SCORE_W+4*d +: 4] = r[SCORE_W+4*d +: 4] + 4'd3;
    return {r[SR_W-2:0], 1'b0};
  endfunction

  function automatic logic [BCD_W-1:0] sat_bcd(input logic [SCORE_W-1:0] v,
                                               input logic [BCD_W-1:0]   b);
    return (v > MAX_DISP) ? {DIGITS{4'h9}} : b;
  endfunction

  typedef enum logic [1:0] {IDLE, INSERT, CONVERT} state_t;

  state_t             state;
  logic [SCORE_W-1:0] tbl   [DEPTH];
  logic [BCD_W-1:0]   cache [DEPTH];
  logic [SCORE_W-1:0] grade;
  logic               lose_d;
  logic               ev;
  logic [2:0]         e;
  logic [BC_W-1:0]    bcnt;
  logic [SR_W-1:0]    sr;
  logic [SR_W-1:0]    sr_next;
  logic [SCORE_W-1:0] cur;
  logic [BCD_W-1:0]   bcd_new;
  logic [SCORE_W-1:0] ins_tbl [DEPTH];
  logic [SCORE_W-1:0] shifted [DEPTH];
  logic [3:0]         ins_rank;
  logic               ins_hit;
  logic [SCORE_W-1:0] rd_score_p0, rd_score_p1;
  logic [BCD_W-1:0]   rd_bcd_p0, rd_bcd_p1;
  logic               busy_r, done_r, dropped_r;
  logic [3:0]         new_rank_r;

  assign ev = bus.lose & ~lose_d;

  // Insertion point: descending scan leaves the lowest matching index, so a
  // new score lands above an existing equal entry.
  always_comb begin
    ins_hit  = 1'b0;
    ins_rank = 4'(DEPTH);
    for (int i = DEPTH - 1; i >= 0; i--)
      if (grade >= tbl[i]) begin
        ins_hit  = 1'b1;
        ins_rank = 4'(i);
      end
    shifted[0] = grade;
    for (int i = 1; i < DEPTH; i++) shifted[i] = tbl[i-1];
    for (int i = 0; i < DEPTH; i++) begin
      if (!ins_hit || (4'(i) < ins_rank)) ins_tbl[i] = tbl[i];
      else if (4'(i) == ins_rank)         ins_tbl[i] = grade;
      else                                ins_tbl[i] = shifted[i];
    end
  end

  always_comb begin
    cur = '0;
    for (int i = 0; i < DEPTH; i++)
      if (e == 3'(i)) cur = tbl[i];
    // The first bit of each entry loads the binary value straight from the table.
    sr_next = dd_step((bcnt == '0) ? {{BCD_W{1'b0}}, cur} : sr);
    bcd_new = sat_bcd(cur, sr_next[SR_W-1 -: BCD_W]);
  end

  always_comb begin
    rd_score_p0 = '0;
    rd_bcd_p0   = '0;
    for (int i = 0; i < DEPTH; i++)
      if (bus.rd_idx == 3'(i)) begin
        rd_score_p0 = tbl[i];
        rd_bcd_p0   = cache[i];
      end
  end

  // p0 -> p1: read port register; FSM and table state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      for (int i = 0; i < DEPTH; i++) begin
        tbl[i]   <= '0;
        cache[i] <= '0;
      end
      grade       <= '0;
      lose_d      <= 1'b0;
      e           <= '0;
      bcnt        <= '0;
      sr          <= '0;
      rd_score_p1 <= '0;
      rd_bcd_p1   <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      dropped_r   <= 1'b0;
      new_rank_r  <= 4'(DEPTH);
    end else begin
      lose_d      <= bus.lose;
      if (!bus.lose) grade <= bus.sec;
      rd_score_p1 <= rd_score_p0;
      rd_bcd_p1   <= rd_bcd_p0;
      done_r      <= 1'b0;
      if (ev && (state != IDLE)) dropped_r <= 1'b1;
      case (state)
        IDLE: begin
          if (ev) begin
            state  <= INSERT;
            busy_r <= 1'b1;
          end else if (bus.clr) begin
            for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
            dropped_r <= 1'b0;
            e         <= '0;
            bcnt      <= '0;
            state     <= CONVERT;
            busy_r    <= 1'b1;
          end
        end
        INSERT: begin
          for (int i = 0; i < DEPTH; i++) tbl[i] <= ins_tbl[i];
          new_rank_r <= ins_rank;
          e          <= '0;
          bcnt       <= '0;
          state      <= CONVERT;
        end
        CONVERT: begin
          sr <= sr_next;
          if (bcnt == BC_W'(SCORE_W - 1)) begin
            for (int i = 0; i < DEPTH; i++)
              if (e == 3'(i)) cache[i] <= bcd_new;
            bcnt <= '0;
            if (e == 3'(DEPTH - 1)) begin
              state  <= IDLE;
              busy_r <= 1'b0;
              done_r <= 1'b1;
            end else begin
              e <= e + 3'd1;
            end
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rd_score = rd_score_p1;
  assign bus.rd_bcd   = rd_bcd_p1;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.new_rank = new_rank_r;
  assign bus.dropped  = dropped_r;

endmodule

// File: tb/tb_leaderboard_recorder.sv
module tb_leaderboard_recorder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [13:0] sec = '0;
  logic        lose = 1'b0;
  logic        clr = 1'b0;
  logic [2:0]  rd_idx = '0;
  logic        cfg_b = 1'b0;

  always #5 clk = ~clk;

  leaderboard_recorder_if #(.SCORE_W(10), .DIGITS(3)) ifa ();
  leaderboard_recorder_if #(.SCORE_W(14), .DIGITS(4)) ifb ();

  assign ifa.sec = sec[9:0];
  assign ifa.lose = lose;
  assign ifa.clr = clr;
  assign ifa.rd_idx = rd_idx;
  assign ifb.sec = sec;
  assign ifb.lose = lose;
  assign ifb.clr = clr;
  assign ifb.rd_idx = rd_idx;

  leaderboard_recorder #(.SCORE_W(10), .DEPTH(3), .DIGITS(3)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa.slave));
  leaderboard_recorder #(.SCORE_W(14), .DEPTH(5), .DIGITS(4)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb.slave));

  logic [15:0] o_score, o_bcd;
  logic        o_busy, o_done, o_dropped;
  logic [3:0]  o_rank;
  always_comb begin
    o_score   = cfg_b ? {2'b0, ifb.rd_score} : {6'b0, ifa.rd_score};
    o_bcd     = cfg_b ? ifb.rd_bcd : {4'b0, ifa.rd_bcd};
    o_busy    = cfg_b ? ifb.busy : ifa.busy;
    o_done    = cfg_b ? ifb.done : ifa.done;
    o_dropped = cfg_b ? ifb.dropped : ifa.dropped;
    o_rank    = cfg_b ? ifb.new_rank : ifa.new_rank;
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int to_bcd(input int v, input int dig);
    int p, r;
    p = 1;
    r = 0;
    for (int k = 0; k < dig; k++) p = p * 10;
    if (v > p - 1) begin
      for (int k = 0; k < dig; k++) r = r | (9 << (4 * k));
      return r;
    end
    for (int k = 0; k < dig; k++) begin
      r = r | ((v % 10) << (4 * k));
      v = v / 10;
    end
    return r;
  endfunction

  // Behavioural model: table as a ranked list, engine as a countdown of busy cycles.
  int m_depth = 3, m_w = 10, m_dig = 3;
  int m_tab [8];
  int m_cache [8];
  int m_grade, m_lose_d, m_left, m_pending, m_rank, m_dropped, m_done;

  always @(posedge clk) begin
    int c_lose, c_clr, c_sec, c_idx, c_rst, ev, pos, exp_s, exp_b, chk_bcd;
    int q[$];
    c_lose = lose; c_clr = clr; c_idx = rd_idx; c_rst = rst;
    c_sec = int'(sec) & ((1 << m_w) - 1);
    #1;
    if (c_rst) begin
      for (int i = 0; i < 8; i++) begin m_tab[i] = 0; m_cache[i] = 0; end
      m_grade = 0; m_lose_d = 0; m_left = 0; m_pending = 0;
      m_rank = m_depth; m_dropped = 0; m_done = 0;
      exp_s = 0; exp_b = 0; chk_bcd = 1;
    end else begin
      exp_s   = (c_idx < m_depth) ? m_tab[c_idx] : 0;
      exp_b   = (c_idx < m_depth) ? m_cache[c_idx] : 0;
      chk_bcd = (m_left == 0);
      ev = c_lose && !m_lose_d;
      m_done = 0;
      if (m_left > 0) begin
        if (m_pending) begin
          q = {};
          for (int i = 0; i < m_depth; i++) q.push_back(m_tab[i]);
          pos = -1;
          for (int i = 0; i < m_depth; i++)
            if (m_grade >= q[i]) begin pos = i; break; end
          if (pos >= 0) begin
            q.insert(pos, m_grade);
            void'(q.pop_back());
            for (int i = 0; i < m_depth; i++) m_tab[i] = q[i];
            m_rank = pos;
          end else m_rank = m_depth;
          m_pending = 0;
        end
        m_left--;
        if (m_left == 0) begin
          m_done = 1;
          for (int i = 0; i < m_depth; i++) m_cache[i] = to_bcd(m_tab[i], m_dig);
        end
        if (ev) m_dropped = 1;
      end else if (ev) begin
        m_left = 1 + m_depth * m_w;
        m_pending = 1;
      end else if (c_clr) begin
        for (int i = 0; i < 8; i++) m_tab[i] = 0;
        m_dropped = 0;
        m_left = m_depth * m_w;
      end
      if (!c_lose) m_grade = c_sec;
      m_lose_d = c_lose;
    end
    chk("m_busy", o_busy, (m_left > 0) ? 1 : 0);
    chk("m_done", o_done, m_done);
    chk("m_new_rank", o_rank, m_rank);
    chk("m_dropped", o_dropped, m_dropped);
    chk("m_rd_score", o_score, exp_s);
    if (chk_bcd) chk("m_rd_bcd", o_bcd, exp_b);
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (o_busy && n < 400) begin @(negedge clk); n++; end
    chk("idle_timeout", o_busy, 0);
    @(negedge clk);
  endtask

  task automatic rd(input int idx, input int exp_s, input int exp_b, input string nm);
    @(negedge clk) rd_idx = 3'(idx);
    @(negedge clk);
    chk({nm, "_score"}, o_score, exp_s);
    chk({nm, "_bcd"}, o_bcd, exp_b);
  endtask

  task automatic play(input int score, output int ins_to_done, output int ndone);
    int t_ins, t_done;
    @(negedge clk) sec = 14'(score);
    @(negedge clk) lose = 1'b1;
    t_ins = -1; t_done = -1; ndone = 0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (o_busy && t_ins < 0) t_ins = n;
      if (o_done) begin ndone++; t_done = n; end
    end
    lose = 1'b0;
    wait_idle();
    ins_to_done = t_done - t_ins;
  endtask

  task automatic rand_run(input int cycles, input int w);
    for (int n = 0; n < cycles; n++) begin
      @(negedge clk);
      rd_idx = 3'($urandom_range(0, 7));
      clr = ($urandom_range(0, 99) == 0);
      if (!lose) begin
        if ($urandom_range(0, 19) == 0) lose = 1'b1;
        else if ($urandom_range(0, 3) == 0)
          sec = ($urandom_range(0, 1) == 0) ? 14'($urandom_range(0, 15))
                                            : 14'($urandom_range(0, (1 << w) - 1));
      end else if ($urandom_range(0, 14) == 0) lose = 1'b0;
    end
    @(negedge clk);
    lose = 1'b0; clr = 1'b0;
    wait_idle();
  endtask

  initial begin
    int d, nd, t_busy, t_done;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 3; i++) rd(i, 0, 0, "reset_rd");
    chk("reset_rank", o_rank, 3);
    chk("reset_busy", o_busy, 0);

    play(42, d, nd);
    chk("g42_done_count", nd, 1);
    chk("g42_ins_to_done", d, 31);
    chk("g42_rank", o_rank, 0);
    rd(0, 42, 'h042, "g42_idx0");
    rd(1, 0, 0, "g42_idx1");
    rd(2, 0, 0, "g42_idx2");

    @(negedge clk) clr = 1'b1;
    @(negedge clk) clr = 1'b0;
    wait_idle();
    play(50, d, nd); chk("g50a_rank", o_rank, 0);
    play(50, d, nd); chk("g50b_rank", o_rank, 0);
    play(7, d, nd);  chk("g7_rank", o_rank, 2);
    play(99, d, nd); chk("g99_rank", o_rank, 0);
    play(3, d, nd);  chk("g3_rank", o_rank, 3);
    play(50, d, nd); chk("tie50_rank", o_rank, 1);
    rd(0, 99, 'h099, "seq_idx0");
    rd(1, 50, 'h050, "seq_idx1");
    rd(2, 50, 'h050, "seq_idx2");

    play(1023, d, nd);
    rd(0, 1023, 'h999, "sat_idx0");

    @(negedge clk) sec = 14'd200;
    @(negedge clk) lose = 1'b1;
    @(negedge clk) lose = 1'b0;
    @(negedge clk) sec = 14'd300;
    @(negedge clk) lose = 1'b1;
    @(negedge clk) lose = 1'b0;
    wait_idle();
    chk("drop_flag", o_dropped, 1);
    chk("drop_rank", o_rank, 1);
    rd(0, 1023, 'h999, "drop_idx0");
    rd(1, 200, 'h200, "drop_idx1");
    rd(2, 99, 'h099, "drop_idx2");

    @(negedge clk) clr = 1'b1;
    t_busy = -1; t_done = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      clr = 1'b0;
      if (o_busy && t_busy < 0) t_busy = n;
      if (o_done) t_done = n;
    end
    chk("clr_to_done", t_done - t_busy, 30);
    chk("clr_dropped", o_dropped, 0);
    for (int i = 0; i < 3; i++) rd(i, 0, 0, "clr_rd");

    @(negedge clk) sec = 14'd500;
    @(negedge clk) lose = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_rank", o_rank, 3);
    chk("rst_dropped", o_dropped, 0);
    chk("rst_score", o_score, 0);
    chk("rst_bcd", o_bcd, 0);
    lose = 1'b0;
    @(negedge clk) rst = 1'b0;
    play(12, d, nd);
    rd(0, 12, 'h012, "post_rst_idx0");
    rd(1, 0, 0, "post_rst_idx1");
    rd(2, 0, 0, "post_rst_idx2");

    rand_run(3000, 10);

    @(negedge clk);
    rst = 1'b1; cfg_b = 1'b1;
    m_depth = 5; m_w = 14; m_dig = 4;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    play(9999, d, nd);  chk("b9999_rank", o_rank, 0);
    chk("b_ins_to_done", d, 71);
    play(10000, d, nd); chk("b10000_rank", o_rank, 0);
    play(0, d, nd);     chk("b0_rank", o_rank, 2);
    play(17, d, nd);    chk("b17_rank", o_rank, 2);
    rd(0, 10000, 'h9999, "b_idx0");
    rd(1, 9999, 'h9999, "b_idx1");
    rd(2, 17, 'h0017, "b_idx2");
    rd(6, 0, 0, "b_idx6");

    rand_run(3000, 14);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
